// File: rtl/par_mult_responder.sv
// Responder for the parity-protected multiply handshake: checks operand parity and
// returns the signed product. Define PAR_MULT_FAST_EN for a single-cycle multiplier instead of the shift-add engine.
module par_mult_responder #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     arg_a,
    input  logic                  arg_a_parity,
    input  logic [DATA_W-1:0]     arg_b,
    input  logic                  arg_b_parity,
    input  logic                  req,
    output logic                  ack,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_parity,
    output logic                  result_rdy,
    output logic                  arg_parity_error
);

    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        CALC,
        DONE
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] a_q, b_q;
    logic              err_q;
    logic              sign_q;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  a_ext, b_ext;
    logic [RES_W-1:0]  prod;

`ifndef PAR_MULT_FAST_EN
    logic [RES_W-1:0]  mcand, mplier;
    logic [CNT_W-1:0]  cnt;
    logic [RES_W-1:0]  a_abs, b_abs;
`endif

    // Magnitudes are taken after sign extension so the most negative operand cannot wrap.
    always_comb begin
        a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
        b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};
`ifndef PAR_MULT_FAST_EN
        a_abs = a_q[DATA_W-1] ? (~a_ext + 1'b1) : a_ext;
        b_abs = b_q[DATA_W-1] ? (~b_ext + 1'b1) : b_ext;
`endif
        prod  = sign_q ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req) state_n = ACK;
`ifdef PAR_MULT_FAST_EN
            ACK:  state_n = DONE;
            CALC: state_n = DONE;
`else
            ACK:  state_n = err_q ? DONE : CALC;
            CALC: if (cnt == CNT_W'(DATA_W - 1)) state_n = DONE;
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack              <= 1'b0;
            result_rdy       <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
            a_q              <= '0;
            b_q              <= '0;
            err_q            <= 1'b0;
            sign_q           <= 1'b0;
            acc              <= '0;
`ifndef PAR_MULT_FAST_EN
            mcand            <= '0;
            mplier           <= '0;
            cnt              <= '0;
`endif
        end else begin
            ack        <= (state == IDLE) && req;
            result_rdy <= (state == DONE);
            case (state)
                IDLE: begin
                    if (req) begin
                        a_q   <= arg_a;
                        b_q   <= arg_b;
                        err_q <= (arg_a_parity ^ (^arg_a)) | (arg_b_parity ^ (^arg_b));
                    end
                end
                ACK: begin
`ifdef PAR_MULT_FAST_EN
                    acc    <= $signed(a_ext) * $signed(b_ext);
                    sign_q <= 1'b0;
`else
                    acc    <= '0;
                    mcand  <= a_abs;
                    mplier <= b_abs;
                    sign_q <= a_q[DATA_W-1] ^ b_q[DATA_W-1];
                    cnt    <= '0;
`endif
                end
`ifndef PAR_MULT_FAST_EN
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
`endif
                DONE: begin
                    if (err_q) begin
                        result           <= '0;
                        result_parity    <= 1'b0;
                        arg_parity_error <= 1'b1;
                    end else begin
                        result           <= prod;
                        result_parity    <= ^prod;
                        arg_parity_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_par_mult_responder.sv
// Randomized bench for par_mult_responder: a transaction-level model predicts every
// output each cycle, and directed cases pin literal results and latencies.
module tb_par_mult_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] arg_a, arg_b;
    logic        arg_a_parity, arg_b_parity;
    logic        req;
    logic        ack;
    logic [31:0] result;
    logic        result_parity;
    logic        result_rdy;
    logic        arg_parity_error;

    int errors = 0;
    int checks = 0;

`ifdef PAR_MULT_FAST_EN
    localparam int LAT_OK = 2;
`else
    localparam int LAT_OK = 18;
`endif
    localparam int LAT_ERR = 2;

    par_mult_responder #(.DATA_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .arg_a            (arg_a),
        .arg_a_parity     (arg_a_parity),
        .arg_b            (arg_b),
        .arg_b_parity     (arg_b_parity),
        .req              (req),
        .ack              (ack),
        .result           (result),
        .result_parity    (result_parity),
        .result_rdy       (result_rdy),
        .arg_parity_error (arg_parity_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p[31:0];
    endfunction

    // Transaction-level model: busy countdown from acceptance to the result pulse.
    logic        m_busy, m_ack, m_rdy, m_par, m_err;
    logic [31:0] m_res;
    int          m_wait;
    logic [31:0] p_res;
    logic        p_par, p_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_ack <= 1'b0; m_rdy <= 1'b0;
            m_res  <= '0;   m_par <= 1'b0; m_err <= 1'b0;
            m_wait <= 0;
        end else begin
            m_ack <= 1'b0;
            m_rdy <= 1'b0;
            if (m_busy) begin
                if (m_wait == 1) begin
                    m_busy <= 1'b0;
                    m_rdy  <= 1'b1;
                    m_res  <= p_res;
                    m_par  <= p_par;
                    m_err  <= p_err;
                end else begin
                    m_wait <= m_wait - 1;
                end
            end else if (req) begin
                logic        e;
                logic [31:0] r;
                e = (arg_a_parity ^ (^arg_a)) | (arg_b_parity ^ (^arg_b));
                r = e ? 32'h0 : model_prod(arg_a, arg_b);
                p_err  <= e;
                p_res  <= r;
                p_par  <= ^r;
                m_busy <= 1'b1;
                m_ack  <= 1'b1;
                m_wait <= e ? LAT_ERR : LAT_OK;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("ack", {31'b0, ack}, {31'b0, m_ack});
        chk("result_rdy", {31'b0, result_rdy}, {31'b0, m_rdy});
        chk("result", result, m_res);
        chk("result_parity", {31'b0, result_parity}, {31'b0, m_par});
        chk("arg_parity_error", {31'b0, arg_parity_error}, {31'b0, m_err});
    end

    // One transaction; optionally checks literal result/latency and scrambles operands while busy.
    task automatic txn(input logic [15:0] a, input logic pa, input logic [15:0] b, input logic pb,
                       input bit lit, input logic [31:0] er, input logic ep, input logic ee,
                       input int elat, input bit toggle);
        int k;
        int lat;
        @(negedge clk);
        arg_a = a; arg_a_parity = pa;
        arg_b = b; arg_b_parity = pb;
        req = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ack && k < 40) begin
            @(negedge clk);
            k++;
        end
        req = 1'b0;
        if (!ack) begin
            chk("ack_timeout", 32'd0, 32'd1);
            return;
        end
        lat = 0;
        while (lat < 60) begin
            if (toggle) begin
                arg_a = 16'($urandom);
                arg_b = 16'($urandom);
            end
            @(negedge clk);
            lat++;
            if (result_rdy) break;
        end
        if (!result_rdy) begin
            chk("rdy_timeout", 32'd0, 32'd1);
            return;
        end
        if (lit) begin
            chk("latency", 32'(lat), 32'(elat));
            chk("lit_result", result, er);
            chk("lit_parity", {31'b0, result_parity}, {31'b0, ep});
            chk("lit_error", {31'b0, arg_parity_error}, {31'b0, ee});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, rdys, k;
        logic [15:0] a, b;
        logic pa, pb;

        rst_n = 1'b0;
        req = 1'b0;
        arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;

        chk("model_pin_minmin", model_prod(16'h8000, 16'h8000), 32'h40000000);
        chk("model_pin_minmax", model_prod(16'h8000, 16'h7FFF), 32'hC0008000);

        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {28'b0, ack, result_rdy, result_parity, arg_parity_error}, 32'h0);
        rst_n = 1'b1;

        // Basic and corner products, parity error
        txn(16'h0003, 1'b0, 16'h0005, 1'b0, 1'b1, 32'h0000000F, 1'b0, 1'b0, LAT_OK, 1'b0);
        txn(16'h8000, 1'b1, 16'h8000, 1'b1, 1'b1, 32'h40000000, 1'b1, 1'b0, LAT_OK, 1'b0);
        txn(16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b1, 32'hC0008000, 1'b1, 1'b0, LAT_OK, 1'b0);
        txn(16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, LAT_ERR, 1'b0);

        // req held across two transactions
        @(negedge clk);
        arg_a = 16'h0002; arg_a_parity = 1'b1;
        arg_b = 16'h0003; arg_b_parity = 1'b0;
        req = 1'b1;
        acks = 0; rdys = 0; k = 0;
        while (rdys < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (ack) acks++;
            if (result_rdy) begin
                rdys++;
                chk("b2b_result", result, 32'h00000006);
                chk("b2b_parity", {31'b0, result_parity}, 32'h0);
            end
        end
        req = 1'b0;
        chk("b2b_rdy_count", 32'(rdys), 32'd2);
        chk("b2b_ack_count", 32'(acks), 32'd2);

        // Reset in the middle of a calculation
        @(negedge clk);
        arg_a = 16'h0003; arg_a_parity = 1'b0;
        arg_b = 16'h0005; arg_b_parity = 1'b0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rdys = 0;
        repeat (25) begin
            @(negedge clk);
            if (result_rdy) rdys++;
        end
        chk("rst_no_rdy", 32'(rdys), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {29'b0, ack, result_parity, arg_parity_error}, 32'h0);
        txn(16'h0003, 1'b0, 16'h0005, 1'b0, 1'b1, 32'h0000000F, 1'b0, 1'b0, LAT_OK, 1'b0);

        // Operands scrambled after capture
        txn(16'h1234, 1'b1, 16'hFEDC, 1'b0, 1'b1, 32'hFFEB3CB0, 1'b1, 1'b0, LAT_OK, 1'b1);

        // Randomized traffic, including corner operands and parity errors
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: a = 16'h8000;
                1: a = 16'h7FFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 16'h8000;
                1: b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            pa = (^a) ^ ($urandom_range(0, 7) == 0);
            pb = (^b) ^ ($urandom_range(0, 7) == 0);
            txn(a, pa, b, pb, 1'b0, 32'h0, 1'b0, 1'b0, 0, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par_mult_responder.md
Name: par_mult_responder

Overview:
Responder end of the team's parity-protected multiply handshake. The block accepts two signed 16-bit operands, each with an even-parity bit, under a req/ack handshake, and checks both parity bits. It computes the signed product with an iterative shift-add engine and returns a 32-bit result with its parity bit and a one-cycle result_rdy pulse. The block is the synthesizable counterpart to the team's multiply initiators and testbench drivers.

Parameters:
DATA_W, 16, operand width in bits; result width is 2*DATA_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low; the block has one clock, and reset is asynchronous and active-low.
arg_a  input  DATA_W  signed operand A; valid while req=1.
arg_a_parity  input  1  even-parity bit for arg_a (expected value ^arg_a).
arg_b  input  DATA_W  signed operand B.
arg_b_parity  input  1  even-parity bit for arg_b.
req  input  1  initiator request; operands valid.
ack  output  1  one-cycle acknowledge: operands captured.
result  output  2*DATA_W  signed product.
result_parity  output  1  ^result.
result_rdy  output  1  one-cycle pulse: result/result_parity/arg_parity_error valid.
arg_parity_error  output  1  1 = operand parity mismatch for the completed transaction.

Behaviour:
- Reset (rst_n=0, any time): state=IDLE; ack, result_rdy, arg_parity_error, result_parity = 0; result = 0. Any in-flight transaction is discarded; no result_rdy after release.
- FSM states: IDLE, ACK, CALC, DONE. All outputs are registered.
- IDLE:
  - On edge E0 with req=1, capture arg_a, arg_b and both parity bits.
  - Compute pa_err = arg_a_parity ^ (^arg_a) and pb_err likewise. Go to ACK.
  - req=0 stays in IDLE.
- ACK: ack=1 for exactly the cycle E0..E1.
  - At E1, if pa_err|pb_err, go to DONE.
  - Otherwise load the engine with |a|, |b| (2*DATA_W-bit unsigned), sign = a[msb]^b[msb], and counter=0. Go to CALC.
- CALC: one multiplier bit per cycle; the accumulator adds the shifted |a| when the current bit of |b| is 1. After DATA_W steps (edges E2..E17), go to DONE.
- DONE:
  - result_rdy=1 for one cycle.
  - With no parity error: result = sign ? -acc : acc, truncated to 2*DATA_W bits. result_parity = ^result. arg_parity_error=0.
  - With a parity error: result=0, result_parity=0, arg_parity_error=1.
  - Return to IDLE next edge.
- Latency from the sampling edge to the result_rdy rising edge:
  - DATA_W+2 cycles (18 at default) without error.
  - 2 cycles with a parity error.
- result, result_parity and arg_parity_error hold their values after result_rdy drops, until the next DONE or reset.
- req is ignored while not in IDLE: no second ack and no capture. Operand changes after the sampling edge have no effect.
- If req is still 1 when the FSM returns to IDLE, a new transaction is accepted on that edge (back-to-back). Initiators must drop req after seeing ack.
- Arithmetic corner cases: the product always fits in 2*DATA_W bits, with no overflow.
  - -32768*-32768 = 0x40000000.
  - -32768*32767 = 0xC0008000.
  - |-32768| must be computed in 2*DATA_W bits (no 16-bit wrap).

Optional Feature:
PAR_MULT_FAST_EN:
- Defined: CALC is bypassed. At E1 the signed product is computed combinationally (a*b, 2*DATA_W bits) and registered, and the FSM goes straight to DONE. Latency is 2 cycles for both valid and error transactions.
- Undefined: the iterative engine above is used, with DATA_W+2 cycle latency.
- Ports, handshake and error behaviour are identical in both builds.

Test Plan:
1. Reset, then req with a=0x0003/p0, b=0x0005/p0 -> ack one cycle; result_rdy 18 cycles after sampling edge; result=0x0000000F, result_parity=0, arg_parity_error=0.
2. a=0x8000/p1, b=0x8000/p1 -> result=0x40000000, parity=1. Then a=0x8000/p1, b=0x7FFF/p1 -> result=0xC0008000, parity=1.
3. a=0xFFFF/p0, b=0x0001/p0 (wrong b parity) -> result_rdy 2 cycles after sampling, arg_parity_error=1, result=0, result_parity=0.
4. Hold req=1 across a whole transaction with a=0x0002/p1, b=0x0003/p0 -> exactly one ack per transaction; a second transaction starts on the IDLE-return edge; both yield result=0x00000006, parity=0.
5. Assert rst_n=0 during CALC, release, and do not raise req -> no result_rdy; all outputs 0. A following request completes normally.
6. Toggle arg_a/arg_b during CALC -> result equals the product of the captured operands; ack is not reasserted.
